// File: rtl/stopwatch_pkg.sv
// +------------------------------------------------------------------+
// | stopwatch_pkg: shared types and constants for stopwatch_ms        |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam bcd_t UNITS_MAX = 4'd9;
  localparam bcd_t TENS_MAX  = 4'd5;

  // Advance one BCD digit, wrapping to zero past its maximum.
  function automatic bcd_t digit_inc(input bcd_t d, input bcd_t max);
    return (d == max) ? 4'd0 : bcd_t'(d + 4'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_edge.sv
// +------------------------------------------------------------------+
// | btn_edge: optional 2-FF synchronizer plus rising-edge detector    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module btn_edge #(
  parameter int SYNC = 1
) (
  input  logic clk,
  input  logic R,
  input  logic btn,
  output logic pulse
);

  logic lvl;
  logic prev_q;
  logic init_q;

  // The first sample after reset primes every stage, so a held level gives no edge.
  generate
    if (SYNC != 0) begin : g_sync2
      logic s1_q, s2_q;
      always_ff @(posedge clk) begin
        if (R) begin
          s1_q <= 1'b0;
          s2_q <= 1'b0;
        end else if (!init_q) begin
          s1_q <= btn;
          s2_q <= btn;
        end else begin
          s1_q <= btn;
          s2_q <= s1_q;
        end
      end
      assign lvl = s2_q;
    end else begin : g_sync1
      logic s1_q;
      always_ff @(posedge clk) begin
        if (R) s1_q <= 1'b0;
        else   s1_q <= btn;
      end
      assign lvl = s1_q;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (R) begin
      prev_q <= 1'b0;
      init_q <= 1'b0;
    end else if (!init_q) begin
      prev_q <= btn;
      init_q <= 1'b1;
    end else begin
      prev_q <= lvl;
    end
  end

  assign pulse = init_q & lvl & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/stopwatch_ms.sv
// +------------------------------------------------------------------+
// | stopwatch_ms: MM:SS BCD up-counting stopwatch with lap freeze     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module stopwatch_ms
  import stopwatch_pkg::*;
#(
  parameter int SYNC = 1
) (
  input  logic        clk,
  input  logic        R,
  input  logic        ce1s,
  input  logic        BTN_ss,
  input  logic        BTN_lap,
  input  logic        BTN_clr,
  output logic [15:0] dat,
  output logic        RUN,
  output logic        LAP,
  output logic        CO
);

  logic ss_p, lap_p, clr_p;

  btn_edge #(.SYNC(SYNC)) u_ss  (.clk(clk), .R(R), .btn(BTN_ss),  .pulse(ss_p));
  btn_edge #(.SYNC(SYNC)) u_lap (.clk(clk), .R(R), .btn(BTN_lap), .pulse(lap_p));
  btn_edge #(.SYNC(SYNC)) u_clr (.clk(clk), .R(R), .btn(BTN_clr), .pulse(clr_p));

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] lap_q, lap_d;
  logic        hold_q, hold_d;
  logic        co_q, co_d;

  logic [15:0] count_inc;
  logic        wrap;

  // Ripple carry through the four BCD digits.
  always_comb begin
    count_inc       = count_q;
    wrap            = 1'b0;
    count_inc[3:0]  = digit_inc(count_q[3:0], UNITS_MAX);
    if (count_q[3:0] == UNITS_MAX) begin
      count_inc[7:4] = digit_inc(count_q[7:4], TENS_MAX);
      if (count_q[7:4] == TENS_MAX) begin
        count_inc[11:8] = digit_inc(count_q[11:8], UNITS_MAX);
        if (count_q[11:8] == UNITS_MAX) begin
          count_inc[15:12] = digit_inc(count_q[15:12], TENS_MAX);
          wrap             = (count_q[15:12] == TENS_MAX);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    lap_d   = lap_q;
    hold_d  = hold_q;
    co_d    = 1'b0;

    // Counting follows the registered state, independent of this cycle's buttons.
    if (ce1s && state_q == RUNNING) begin
      count_d = count_inc;
      co_d    = wrap;
    end

    if (clr_p) begin
      hold_d = 1'b0;
      if (state_q == PAUSED) begin
        state_d = IDLE;
        count_d = '0;
        lap_d   = '0;
      end
    end else if (ss_p) begin
      unique case (state_q)
        IDLE:    state_d = RUNNING;
        RUNNING: state_d = PAUSED;
        PAUSED:  state_d = RUNNING;
        default: state_d = IDLE;
      endcase
    end else if (lap_p) begin
      if (state_q == RUNNING) begin
        hold_d = ~hold_q;
        if (!hold_q) lap_d = count_q;
      end else begin
        hold_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (R) begin
      state_q <= IDLE;
      count_q <= '0;
      lap_q   <= '0;
      hold_q  <= 1'b0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lap_q   <= lap_d;
      hold_q  <= hold_d;
      co_q    <= co_d;
    end
  end

  assign dat = hold_q ? lap_q : count_q;
  assign RUN = (state_q == RUNNING);
  assign LAP = hold_q;
  assign CO  = co_q;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_ms.sv
// +------------------------------------------------------------------+
// | tb_stopwatch_ms: scoreboard bench with a seconds-based model      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_stopwatch_ms;

  logic        clk = 1'b0;
  logic        R, ce1s, BTN_ss, BTN_lap, BTN_clr;
  logic [15:0] dat;
  logic        RUN, LAP, CO;

  int checks = 0;
  int errors = 0;

  stopwatch_ms #(.SYNC(1)) dut (
    .clk(clk), .R(R), .ce1s(ce1s),
    .BTN_ss(BTN_ss), .BTN_lap(BTN_lap), .BTN_clr(BTN_clr),
    .dat(dat), .RUN(RUN), .LAP(LAP), .CO(CO)
  );

  always #5 clk = ~clk;

  // Reference model: elapsed time kept as plain seconds, converted to BCD on output.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;
  int         m_sec, m_lap, m_st;
  bit         m_hold, m_co, m_init;
  logic [2:0] h0, h1, h2, ev, cur;
  logic [18:0] exp_q[$];

  function automatic logic [15:0] to_bcd(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  always @(posedge clk) begin
    if (R) begin
      m_sec = 0; m_lap = 0; m_st = M_IDLE; m_hold = 0; m_co = 0; m_init = 0;
    end else begin
      cur = {BTN_ss, BTN_lap, BTN_clr};
      if (!m_init) begin
        h0 = cur; h1 = cur; h2 = cur; ev = 3'b000; m_init = 1;
      end else begin
        ev = h1 & ~h2;
        h2 = h1; h1 = h0; h0 = cur;
      end
      m_co = 0;
      begin
        bit inc;
        inc = (m_st == M_RUN) && ce1s;
        if (ev[0]) begin
          m_hold = 0;
          if (m_st == M_PAUSE) begin m_st = M_IDLE; m_sec = 0; m_lap = 0; end
        end else if (ev[2]) begin
          m_st = (m_st == M_RUN) ? M_PAUSE : M_RUN;
        end else if (ev[1]) begin
          if (m_st == M_RUN) begin
            if (!m_hold) m_lap = m_sec;
            m_hold = !m_hold;
          end else m_hold = 0;
        end
        if (inc) begin
          m_co  = (m_sec == 3599);
          m_sec = (m_sec + 1) % 3600;
        end
      end
    end
    exp_q.push_back({to_bcd(m_hold ? m_lap : m_sec), m_st == M_RUN, m_hold, m_co});
  end

  bit co_seen;
  always @(negedge clk) begin
    logic [18:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {dat, RUN, LAP, CO};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t: got dat=%h RUN=%b LAP=%b CO=%b, expected dat=%h RUN=%b LAP=%b CO=%b",
                 $time, a[18:3], a[2], a[1], a[0], e[18:3], e[2], e[1], e[0]);
      end
    end
    if (CO === 1'b1) co_seen = 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic press(input logic [2:0] b);
    {BTN_ss, BTN_lap, BTN_clr} = b;
    repeat (3) step();
    {BTN_ss, BTN_lap, BTN_clr} = 3'b000;
    repeat (3) step();
  endtask

  task automatic strobes(input int n);
    ce1s = 1;
    repeat (n) step();
    ce1s = 0;
  endtask

  initial begin
    R = 1; ce1s = 0; BTN_ss = 0; BTN_lap = 0; BTN_clr = 0;
    repeat (3) step();
    R = 0;
    repeat (2) step();
    check("reset", {dat, RUN, LAP, CO}, 19'h0);

    press(3'b100);
    check("start_run", RUN, 1);
    co_seen = 0;
    strobes(75);
    check("count_75", dat, 16'h0115);
    check("run_75", RUN, 1);
    check("no_co_75", co_seen, 0);

    strobes(3523);
    check("preload", dat, 16'h5958);
    strobes(1);
    check("at_5959", {dat, CO}, {16'h5959, 1'b0});
    strobes(1);
    check("wrap", {dat, RUN, CO}, {16'h0000, 1'b1, 1'b1});
    step();
    check("co_one_cycle", CO, 0);

    strobes(10);
    check("at_0010", dat, 16'h0010);
    press(3'b010);
    strobes(5);
    check("lap_freeze", {dat, LAP}, {16'h0010, 1'b1});
    press(3'b010);
    check("lap_release", {dat, LAP}, {16'h0015, 1'b0});

    press(3'b001);
    check("clr_ignored", RUN, 1);
    strobes(1);
    check("clr_count_on", dat, 16'h0016);
    press(3'b100);
    check("paused", RUN, 0);
    press(3'b001);
    check("cleared", {dat, RUN}, {16'h0000, 1'b0});

    press(3'b100);
    strobes(7);
    press(3'b100);
    check("paused_0007", {dat, RUN}, {16'h0007, 1'b0});
    press(3'b101);
    check("clr_beats_ss", {dat, RUN}, {16'h0000, 1'b0});

    press(3'b100);
    strobes(3);
    check("at_0003", dat, 16'h0003);
    BTN_ss = 1;
    step(); step();
    ce1s = 1;
    step();
    ce1s = 0;
    check("ss_with_ce", {dat, RUN}, {16'h0004, 1'b0});
    BTN_ss = 0;
    repeat (3) step();

    press(3'b100);
    strobes(750);
    check("at_1234", dat, 16'h1234);
    press(3'b010);
    strobes(3);
    check("frozen_1234", {dat, LAP}, {16'h1234, 1'b1});
    R = 1; ce1s = 1; BTN_clr = 1;
    step();
    check("mid_reset", {dat, RUN, LAP, CO}, 19'h0);
    ce1s = 0; BTN_clr = 0; BTN_ss = 1;
    step();
    R = 0;
    repeat (6) step();
    check("held_no_start", RUN, 0);
    BTN_ss = 0;
    repeat (3) step();
    press(3'b100);
    check("new_press_start", RUN, 1);

    for (int i = 0; i < 4000; i++) begin
      ce1s = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) BTN_ss  = ~BTN_ss;
      if ($urandom_range(0, 9) == 0) BTN_lap = ~BTN_lap;
      if ($urandom_range(0, 11) == 0) BTN_clr = ~BTN_clr;
      R = ($urandom_range(0, 499) == 0);
      step();
    end
    R = 0; ce1s = 0;
    repeat (2) step();
    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
